stream_mux_shell: RTL and testbench
===================================

STREAM_MUX_SHELL -- requirements
Module: stream_mux_shell

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 128, meaning word width.
REQ-002 SHALL have parameter NUM_BRAM_ADDR_BITS, default 7, meaning per-channel depth DEPTH = 2**NUM_BRAM_ADDR_BITS.
REQ-003 SHALL have parameter NUM_CH, default 4, range 1..16, meaning number of input channels; CH_BITS = max(1, clog2(NUM_CH)).
REQ-004 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port din  in  NUM_CH*PAYLOAD_BITS  channel i payload in bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
REQ-007 SHALL have port val_in  in  NUM_CH  per-channel write valid.
REQ-008 SHALL have port ready_upward  out  NUM_CH  per-channel not-full.
REQ-009 SHALL have port dout  out  PAYLOAD_BITS  merged output word.
REQ-010 SHALL have port dout_ch  out  CH_BITS  source channel of dout.
REQ-011 SHALL have port val_out  out  1  output valid.
REQ-012 SHALL have port ready_downward  in  1  downstream accept.
REQ-013 SHALL have port overflow  out  NUM_CH  sticky per-channel drop flag.

Function
REQ-014 SHALL write channel i word when val_in[i] && ready_upward[i]; transfer out when val_out && ready_downward.
REQ-015 SHALL drive ready_upward[i] = (count_i < DEPTH), count_i width NUM_BRAM_ADDR_BITS+1.
REQ-016 SHALL drop the word and set overflow[i] when val_in[i] && !ready_upward[i]; overflow[i] clears only on reset.
REQ-017 SHALL keep count_i unchanged on simultaneous write and read of channel i; pointers wrap modulo DEPTH.
REQ-018 SHALL provide no write-to-read bypass: word written in cycle t makes channel non-empty in t+1, earliest val_out in t+2.
REQ-019 SHALL issue a read (grant) in cycle t only when some channel is non-empty and (!val_out || ready_downward); at most one grant per cycle.
REQ-020 SHALL assert val_out, dout, dout_ch in cycle t+1 after a grant in t (synchronous-read memory, no extra output register).
REQ-021 SHALL deassert val_out in t+1 when a transfer occurs in t with no grant in t.
REQ-022 SHALL hold dout, dout_ch, val_out stable while val_out && !ready_downward.
REQ-023 SHALL drive dout = 0 whenever val_out = 0; dout_ch holds last granted channel.
REQ-024 SHALL arbitrate round-robin: search starts at channel (last_grant+1) mod NUM_CH; last_grant updates on every grant.
REQ-025 SHALL sustain one transfer per cycle when ready_downward held high and sources non-empty.
REQ-026 SHALL preserve per-channel order; no word duplicated or lost except per REQ-016.
REQ-027 SHALL behave as single FIFO with dout_ch = 0 when NUM_CH = 1.

Reset
REQ-028 SHALL on reset clear all pointers, counts, overflow, val_out, dout, dout_ch to 0 and set last_grant to NUM_CH-1 (channel 0 first).
REQ-029 SHALL discard all buffered and in-flight data on reset asserted mid-operation; ready_upward = all ones and val_out = 0 in the cycle after reset deasserts.
REQ-030 SHALL ignore val_in and ready_downward while reset is high.

Structure
REQ-031 SHALL place clog2 helper function and CH_BITS derivation in shared package stream_pkg.
REQ-032 SHALL instantiate per-channel sub-module stream_fifo_ch (sync-read memory, wr/rd pointers, count, full/empty), NUM_CH instances via generate.
REQ-033 SHALL keep arbiter, output valid logic, and overflow flags in stream_mux_shell top.

Verification
REQ-034 SHALL cover: single write 0xA5 on ch2 at cycle 0, ready_downward=1 -> val_out=1, dout=0xA5, dout_ch=2 at cycle 2.
REQ-035 SHALL cover: ch0..ch3 each preloaded with 3 words, ready_downward=1 -> 12 consecutive transfers, dout_ch sequence 0,1,2,3,0,1,2,3,0,1,2,3.
REQ-036 SHALL cover: val_out high, ready_downward=0 for 5 cycles -> dout/dout_ch unchanged, no channel count decrements.
REQ-037 SHALL cover: 128 writes to ch1 (DEPTH=128) then one more -> ready_upward[1]=0 after 128th, 129th dropped, overflow[1]=1, output yields exactly words 0..127 in order.
REQ-038 SHALL cover: reset asserted with 10 words buffered and val_out=1 -> next cycle val_out=0, dout=0, overflow=0, ready_upward all ones; no stale words emitted afterwards.
REQ-039 SHALL cover: ch3 simultaneous write and read at count=5 -> count remains 5, order preserved.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared helpers for the stream mux shell: ceil-log2 and channel-index width.
package stream_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) result = i + 1;
      else result = result;
    end
    return result;
  endfunction

  // Channel index is never narrower than one bit, even for a single channel.
  function automatic int ch_bits(input int num_ch);
    return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
  endfunction

endpackage

// File: rtl/stream_fifo_ch.sv
// Per-channel FIFO with synchronous-read memory; the read register doubles as
// this channel's share of the merged output bus and self-clears once consumed.
module stream_fifo_ch #(
  parameter int PAYLOAD_BITS = 128,
  parameter int ADDR_BITS    = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [PAYLOAD_BITS-1:0] wr_data,
  input  logic                    rd_en,
  input  logic                    out_taken,
  output logic [PAYLOAD_BITS-1:0] rd_data,
  output logic                    full,
  output logic                    empty
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_CNT = {1'b1, {ADDR_BITS{1'b0}}};

  logic [PAYLOAD_BITS-1:0] mem_r [DEPTH];
  logic [ADDR_BITS-1:0]    wr_ptr_r;
  logic [ADDR_BITS-1:0]    rd_ptr_r;
  logic [ADDR_BITS:0]      count_r;
  logic [PAYLOAD_BITS-1:0] rd_data_r;

  // Storage array, left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_r[wr_ptr_r] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH; count is untouched on simultaneous write and read.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_en) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (rd_en) rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Read register: loads on grant, clears when its word leaves without a re-grant.
  always_ff @(posedge clk) begin
    if (reset)          rd_data_r <= '0;
    else if (rd_en)     rd_data_r <= mem_r[rd_ptr_r];
    else if (out_taken) rd_data_r <= '0;
    else                rd_data_r <= rd_data_r;
  end

  assign rd_data = rd_data_r;
  assign full    = (count_r == DEPTH_CNT);
  assign empty   = (count_r == '0);

endmodule

// File: rtl/stream_mux_shell.sv
// Merges NUM_CH buffered input streams into one output stream using a
// round-robin arbiter; drops and flags writes to a full channel.
module stream_mux_shell
  import stream_pkg::*;
#(
  parameter int PAYLOAD_BITS       = 128,
  parameter int NUM_BRAM_ADDR_BITS = 7,
  parameter int NUM_CH             = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH*PAYLOAD_BITS-1:0] din,
  input  logic [NUM_CH-1:0]              val_in,
  output logic [NUM_CH-1:0]              ready_upward,
  output logic [PAYLOAD_BITS-1:0]        dout,
  output logic [ch_bits(NUM_CH)-1:0]     dout_ch,
  output logic                           val_out,
  input  logic                           ready_downward,
  output logic [NUM_CH-1:0]              overflow
);
  localparam int CH_BITS = ch_bits(NUM_CH);
  localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_CH - 1);

  logic [NUM_CH-1:0]       wr_en_s;
  logic [NUM_CH-1:0]       rd_en_s;
  logic [NUM_CH-1:0]       full_s;
  logic [NUM_CH-1:0]       empty_s;
  logic [PAYLOAD_BITS-1:0] rd_data_s [NUM_CH];
  logic [PAYLOAD_BITS-1:0] dout_s;
  logic [CH_BITS-1:0]      last_grant_r;
  logic [CH_BITS-1:0]      dout_ch_r;
  logic [CH_BITS-1:0]      cand_ch_s;
  logic [CH_BITS-1:0]      scan_ch_s;
  logic                    cand_found_s;
  logic                    grant_s;
  logic                    val_out_r;
  logic                    out_taken_s;
  logic [NUM_CH-1:0]       overflow_r;

  assign out_taken_s = val_out_r & ready_downward;
  assign wr_en_s     = val_in & ~full_s & {NUM_CH{~reset}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    stream_fifo_ch #(
      .PAYLOAD_BITS(PAYLOAD_BITS),
      .ADDR_BITS   (NUM_BRAM_ADDR_BITS)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en_s[i]),
      .wr_data  (din[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_en    (rd_en_s[i]),
      .out_taken(out_taken_s),
      .rd_data  (rd_data_s[i]),
      .full     (full_s[i]),
      .empty    (empty_s[i])
    );
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    cand_found_s = 1'b0;
    cand_ch_s    = last_grant_r;
    scan_ch_s    = last_grant_r;
    for (int k = 0; k < NUM_CH; k++) begin
      if (scan_ch_s == LAST_CH) scan_ch_s = '0;
      else                      scan_ch_s = scan_ch_s + 1'b1;
      if (!cand_found_s && !empty_s[scan_ch_s]) begin
        cand_found_s = 1'b1;
        cand_ch_s    = scan_ch_s;
      end else begin
        cand_found_s = cand_found_s;
      end
    end
  end

  assign grant_s = cand_found_s & (~val_out_r | ready_downward) & ~reset;

  // One-hot read strobe to the granted channel.
  always_comb begin
    rd_en_s = '0;
    if (grant_s) rd_en_s[cand_ch_s] = 1'b1;
    else         rd_en_s = '0;
  end

  // Output valid, source channel and arbiter pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_out_r    <= 1'b0;
      dout_ch_r    <= '0;
      last_grant_r <= LAST_CH;
    end else if (grant_s) begin
      val_out_r    <= 1'b1;
      dout_ch_r    <= cand_ch_s;
      last_grant_r <= cand_ch_s;
    end else if (out_taken_s) begin
      val_out_r    <= 1'b0;
    end else begin
      val_out_r    <= val_out_r;
    end
  end

  // Sticky drop flags.
  always_ff @(posedge clk) begin
    if (reset) overflow_r <= '0;
    else       overflow_r <= overflow_r | (val_in & full_s);
  end

  // Only the channel holding the current word has a non-zero read register.
  always_comb begin
    dout_s = '0;
    for (int i = 0; i < NUM_CH; i++) dout_s = dout_s | rd_data_s[i];
  end

  assign dout         = dout_s;
  assign dout_ch      = dout_ch_r;
  assign val_out      = val_out_r;
  assign ready_upward = ~full_s;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_stream_mux_shell.sv
// Directed, table-driven bench for stream_mux_shell at default parameters.
module tb_stream_mux_shell;
  localparam int PB = 128;

  logic           clk = 1'b0;
  logic           reset;
  logic [4*PB-1:0] din;
  logic [3:0]     val_in;
  logic [3:0]     ready_upward;
  logic [PB-1:0]  dout;
  logic [1:0]     dout_ch;
  logic           val_out;
  logic           ready_downward;
  logic [3:0]     overflow;

  int n_pass  = 0;
  int n_total = 0;

  stream_mux_shell u_dut (
    .clk           (clk),
    .reset         (reset),
    .din           (din),
    .val_in        (val_in),
    .ready_upward  (ready_upward),
    .dout          (dout),
    .dout_ch       (dout_ch),
    .val_out       (val_out),
    .ready_downward(ready_downward),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] val;
    logic [7:0] data;
    logic       rdy;
    logic       exp_val;
    logic [7:0] exp_dout;
    logic [1:0] exp_ch;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic put(input int ch, input logic [7:0] w);
    din[ch*PB +: PB] = PB'(w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; val_in = 4'b0000; ready_downward = 1'b0; din = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int got;
    int stray;
    logic [7:0] exp_w;
    logic [1:0] exp_c;

    reset = 1'b1; val_in = 4'b0000; ready_downward = 1'b0; din = '0;
    // channel i receives data+i each cycle its val bit is set
    vecs[0] = '{4'b0100, 8'hA3, 1'b1, 1'b0, 8'h00, 2'd0};
    vecs[1] = '{4'b0000, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0};
    vecs[2] = '{4'b0000, 8'h00, 1'b1, 1'b1, 8'hA5, 2'd2};
    vecs[3] = '{4'b0000, 8'h00, 1'b1, 1'b0, 8'h00, 2'd2};
    vecs[4] = '{4'b1001, 8'h10, 1'b1, 1'b0, 8'h00, 2'd2};
    vecs[5] = '{4'b0000, 8'h00, 1'b1, 1'b0, 8'h00, 2'd2};
    vecs[6] = '{4'b0000, 8'h00, 1'b1, 1'b1, 8'h13, 2'd3};
    vecs[7] = '{4'b0000, 8'h00, 1'b0, 1'b1, 8'h10, 2'd0};
    vecs[8] = '{4'b0000, 8'h00, 1'b1, 1'b1, 8'h10, 2'd0};
    vecs[9] = '{4'b0000, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0};

    do_reset();
    check("rst_ready", 160'(ready_upward), 160'(4'b1111));
    check("rst_val", 160'(val_out), 160'(1'b0));
    check("rst_dout", 160'(dout), 160'(0));
    check("rst_ch", 160'(dout_ch), 160'(2'd0));
    check("rst_ovf", 160'(overflow), 160'(4'b0000));

    for (int v = 0; v < 10; v++) begin
      check($sformatf("vec%0d_val", v), 160'(val_out), 160'(vecs[v].exp_val));
      check($sformatf("vec%0d_dout", v), 160'(dout), 160'(vecs[v].exp_dout));
      check($sformatf("vec%0d_ch", v), 160'(dout_ch), 160'(vecs[v].exp_ch));
      val_in = vecs[v].val;
      ready_downward = vecs[v].rdy;
      for (int i = 0; i < 4; i++) put(i, vecs[v].data + 8'(i));
      @(negedge clk);
    end

    // Round robin over four preloaded channels, with a 5-cycle stall first.
    do_reset();
    for (int w = 0; w < 3; w++) begin
      val_in = 4'b1111;
      for (int c = 0; c < 4; c++) put(c, 8'(c * 16 + w + 1));
      @(negedge clk);
    end
    val_in = 4'b0000;
    @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      check($sformatf("stall%0d", s), {val_out, dout_ch, 128'(dout)}, {1'b1, 2'd0, 128'(8'h01)});
      @(negedge clk);
    end
    ready_downward = 1'b1;
    for (int j = 0; j < 12; j++) begin
      exp_c = 2'(j % 4);
      exp_w = 8'((j % 4) * 16 + j / 4 + 1);
      check($sformatf("rr%0d", j), {val_out, dout_ch, 128'(dout)}, {1'b1, exp_c, 128'(exp_w)});
      @(negedge clk);
    end
    check("rr_done", 160'(val_out), 160'(1'b0));

    // Fill channel 1 while the output is held by a channel-0 word.
    do_reset();
    val_in = 4'b0001; put(0, 8'hEE);
    @(negedge clk);
    val_in = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check("fill_hold", 160'(val_out), 160'(1'b1));
    for (int w = 0; w < 128; w++) begin
      if (w == 127) check("fill_ready127", 160'(ready_upward), 160'(4'b1111));
      val_in = 4'b0010; put(1, 8'(w));
      @(negedge clk);
    end
    val_in = 4'b0000;
    check("full_ready", 160'(ready_upward), 160'(4'b1101));
    check("full_ovf0", 160'(overflow), 160'(4'b0000));
    val_in = 4'b0010; put(1, 8'h80);
    @(negedge clk);
    val_in = 4'b0000;
    check("drop_ovf", 160'(overflow), 160'(4'b0010));
    ready_downward = 1'b1;
    got = 0;
    for (int t = 0; t < 300; t++) begin
      if (val_out) begin
        exp_c = (got == 0) ? 2'd0 : 2'd1;
        exp_w = (got == 0) ? 8'hEE : 8'(got - 1);
        if (got < 129) check($sformatf("drain%0d", got), {dout_ch, 128'(dout)}, {exp_c, 128'(exp_w)});
        got++;
      end
      @(negedge clk);
    end
    check("drain_count", 160'(got), 160'(129));

    // Reset mid-operation with buffered words and a held output word.
    ready_downward = 1'b0;
    for (int w = 0; w < 5; w++) begin
      val_in = 4'b0101; put(0, 8'(w + 1)); put(2, 8'(w + 8'h41));
      @(negedge clk);
    end
    val_in = 4'b0000;
    @(negedge clk);
    check("pre_rst_val", 160'(val_out), 160'(1'b1));
    check("pre_rst_ovf", 160'(overflow), 160'(4'b0010));
    reset = 1'b1; val_in = 4'b1111; ready_downward = 1'b1;
    @(negedge clk);
    reset = 1'b0; val_in = 4'b0000;
    check("mid_rst", {val_out, overflow, ready_upward, 128'(dout)}, {1'b0, 4'b0000, 4'b1111, 128'(0)});
    stray = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (val_out) stray++;
    end
    check("mid_rst_stray", 160'(stray), 160'(0));

    // Channel 3: simultaneous write and read at count 5.
    do_reset();
    for (int w = 0; w < 6; w++) begin
      val_in = 4'b1000; put(3, 8'(8'h30 + w));
      @(negedge clk);
    end
    val_in = 4'b0000;
    check("c3_count", 160'(u_dut.g_ch[3].u_fifo.count_r), 160'(5));
    check("c3_head", {val_out, 128'(dout)}, {1'b1, 128'(8'h30)});
    val_in = 4'b1000; put(3, 8'h36); ready_downward = 1'b1;
    @(negedge clk);
    val_in = 4'b0000; ready_downward = 1'b0;
    check("c3_count_rw", 160'(u_dut.g_ch[3].u_fifo.count_r), 160'(5));
    check("c3_next", {val_out, dout_ch, 128'(dout)}, {1'b1, 2'd3, 128'(8'h31)});
    ready_downward = 1'b1;
    got = 0;
    for (int t = 0; t < 50; t++) begin
      if (val_out) begin
        if (got < 6) check($sformatf("c3_word%0d", got), {dout_ch, 128'(dout)}, {2'd3, 128'(8'(8'h31 + got))});
        got++;
      end
      @(negedge clk);
    end
    check("c3_count_out", 160'(got), 160'(6));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
